// File: rtl/execute_pipe.sv
// execute_pipe: registered LEGv8 execute stage with ALU, shifts and an iterative
// shift-add multiplier that stalls the upstream stage while busy.
module execute_pipe #(parameter int N = 64) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic         stall_E,
  output logic         valid_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] writeData_M,
  output logic         zero_M
);
  localparam int W = $clog2(N);
  localparam logic IDLE = 1'b0;
  localparam logic MUL = 1'b1;
  logic state;
  logic [W-1:0] cnt;
  logic [N-1:0] acc, mulA, mulB, pcHold, wdHold, opB, aluRes, pcBranch, mulStep;
  logic isMul, lastStep;
  assign opB = AluSrc ? signImm_E : readData2_E;
  assign pcBranch = PC_E + (signImm_E << 2);
  assign isMul = AluControl == 4'b1000;
  assign lastStep = cnt == W'(N - 1);
  assign mulStep = mulB[cnt] ? acc + (mulA << cnt) : acc;
  assign stall_E = state == IDLE ? valid_E & isMul : !lastStep;
  always_comb begin
    case (AluControl)
      4'b0000: aluRes = readData1_E & opB;
      4'b0001: aluRes = readData1_E | opB;
      4'b0010: aluRes = readData1_E + opB;
      4'b0110: aluRes = readData1_E - opB;
      4'b0111: aluRes = opB;
      4'b1100: aluRes = ~(readData1_E | opB);
      4'b1010: aluRes = readData1_E << opB[W-1:0];
      4'b1011: aluRes = readData1_E >> opB[W-1:0];
      default: aluRes = '0;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      mulA <= '0;
      mulB <= '0;
      pcHold <= '0;
      wdHold <= '0;
      valid_M <= 1'b0;
      PCBranch_M <= '0;
      aluResult_M <= '0;
      writeData_M <= '0;
      zero_M <= 1'b0;
    end else if (state == IDLE) begin
      valid_M <= valid_E & !isMul;
      if (valid_E && isMul) begin
        mulA <= readData1_E;
        mulB <= opB;
        pcHold <= pcBranch;
        wdHold <= readData2_E;
        acc <= '0;
        cnt <= '0;
        state <= MUL;
      end else if (valid_E) begin
        PCBranch_M <= pcBranch;
        aluResult_M <= aluRes;
        writeData_M <= readData2_E;
        zero_M <= aluRes == '0;
      end
    end else begin
      acc <= mulStep;
      cnt <= cnt + W'(1);
      valid_M <= lastStep;
      if (lastStep) begin
        state <= IDLE;
        PCBranch_M <= pcHold;
        aluResult_M <= mulStep;
        writeData_M <= wdHold;
        zero_M <= mulStep == '0;
      end
    end
  end
endmodule
